// File: rtl/fetch_pkg.sv
// Shared bus and pipeline types for the fetch stage.
// Bus structs live in common, pipeline register types in pipes.
package common;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

package pipes;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instruction;
    } fetch_data_t;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pcselect.sv
// Next-PC mux for the fetch stage.
// A redirect always wins; REQ offers the sequential PC, other states hold.
module pcselect
    import pipes::*;
(
    input  fetch_state_t state,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    input  logic [63:0]  req_pc,
    input  logic [63:0]  pc,
    output logic [63:0]  npc
);

    always_comb begin
        npc = pc;
        if (redirect_valid)
            npc = redirect_pc & ~64'd3;
        else if (state == REQ)
            npc = req_pc + 64'd4;
    end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: single outstanding request, registered output to decode.
// Redirects during an outstanding request wait in DRAIN for the stale response.
module fetch
    import common::*;
    import pipes::*;
#(
    parameter logic [63:0] PCINIT = 64'h8000_0000
) (
    input  logic         clk,
    input  logic         resetn,
    output ibus_req_t    ireq,
    input  ibus_resp_t   iresp,
    input  logic         stallF,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    output fetch_data_t  dataF
);

    fetch_state_t state;
    logic [63:0]  pc;
    logic [63:0]  req_pc;
    logic [63:0]  npc;

    // addr_ok carries no information for a single-outstanding requester.
    logic unused_addr_ok;
    assign unused_addr_ok = iresp.addr_ok;

    pcselect u_pcselect (
        .state          (state),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_pc         (req_pc),
        .pc             (pc),
        .npc            (npc)
    );

    always_comb begin
        ireq       = '0;
        ireq.valid = resetn && (state != OUT);
        ireq.addr  = req_pc;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= REQ;
            pc     <= PCINIT;
            req_pc <= PCINIT;
            dataF  <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (redirect_valid) begin
                        pc <= npc;
                        if (iresp.data_ok)
                            req_pc <= npc;
                        else
                            state <= DRAIN;
                    end else if (iresp.data_ok) begin
                        dataF.valid       <= 1'b1;
                        dataF.pc          <= req_pc;
                        dataF.instruction <= iresp.data;
                        pc                <= npc;
                        state             <= OUT;
                    end
                end
                DRAIN: begin
                    if (redirect_valid)
                        pc <= npc;
                    if (iresp.data_ok) begin
                        req_pc <= npc;
                        state  <= REQ;
                    end
                end
                OUT: begin
                    // Redirect flushes the held instruction even if decode would take it.
                    if (redirect_valid) begin
                        dataF.valid <= 1'b0;
                        pc          <= npc;
                        req_pc      <= npc;
                        state       <= REQ;
                    end else if (!stallF) begin
                        dataF.valid <= 1'b0;
                        req_pc      <= npc;
                        state       <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: hand-computed vectors checked with immediate assertions.
module tb_fetch;
    import common::*;
    import pipes::*;

    logic        clk;
    logic        resetn;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        stallF;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    fetch_data_t dataF;

    int vectors;
    int miscompares;

    fetch #(.PCINIT(64'h8000_0000)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ireq           (ireq),
        .iresp          (iresp),
        .stallF         (stallF),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dataF          (dataF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, then let one rising edge pass and settle 1 time unit after it.
    task automatic applyStimulus(input logic rv, input logic [63:0] rpc,
                                 input logic dok, input logic [31:0] data,
                                 input logic stall);
        redirect_valid = rv;
        redirect_pc    = rpc;
        iresp.addr_ok  = dok;
        iresp.data_ok  = dok;
        iresp.data     = data;
        stallF         = stall;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkReq(input string tag, input logic v, input logic [63:0] a);
        checkOutput({tag, ".ireq.valid"}, 64'(ireq.valid), 64'(v));
        if (v)
            checkOutput({tag, ".ireq.addr"}, ireq.addr, a);
    endtask

    task automatic checkData(input string tag, input logic v, input logic [63:0] p,
                             input logic [31:0] ins);
        checkOutput({tag, ".dataF.valid"}, 64'(dataF.valid), 64'(v));
        checkOutput({tag, ".dataF.pc"}, dataF.pc, p);
        checkOutput({tag, ".dataF.instruction"}, 64'(dataF.instruction), 64'(ins));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        applyStimulus(0, 64'h0, 0, 32'h0, 0);
        applyStimulus(0, 64'h0, 0, 32'h0, 0);
        checkReq("reset", 0, 64'h0);
        checkData("reset", 0, 64'h0, 32'h0);

        resetn = 1'b1;
        #1;
        checkReq("first_req", 1, 64'h8000_0000);

        applyStimulus(0, 64'h0, 1, 32'h0000_0013, 0);
        checkData("first_data", 1, 64'h8000_0000, 32'h0000_0013);
        checkReq("first_out", 0, 64'h0);

        applyStimulus(0, 64'h0, 0, 32'h0, 0);
        checkReq("seq_req", 1, 64'h8000_0004);
        checkData("consumed", 0, 64'h8000_0000, 32'h0000_0013);

        applyStimulus(0, 64'h0, 1, 32'h0010_0093, 0);
        checkData("second_data", 1, 64'h8000_0004, 32'h0010_0093);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 64'h0, 0, 32'h0, 1);
            checkData("stall_hold", 1, 64'h8000_0004, 32'h0010_0093);
            checkReq("stall_hold", 0, 64'h0);
        end
        applyStimulus(0, 64'h0, 0, 32'h0, 0);
        checkData("stall_release", 0, 64'h8000_0004, 32'h0010_0093);
        checkReq("stall_release", 1, 64'h8000_0008);

        // Late redirect: the request to 0x8000_0008 stays on the bus until its response.
        applyStimulus(1, 64'h8000_0100, 0, 32'h0, 0);
        checkReq("drain0", 1, 64'h8000_0008);
        applyStimulus(0, 64'h0, 0, 32'h0, 1);
        checkReq("drain1", 1, 64'h8000_0008);
        applyStimulus(0, 64'h0, 0, 32'h0, 0);
        checkReq("drain2", 1, 64'h8000_0008);
        checkOutput("drain2.dataF.valid", 64'(dataF.valid), 64'd0);
        applyStimulus(0, 64'h0, 1, 32'hDEAD_BEEF, 0);
        checkReq("post_drain", 1, 64'h8000_0100);
        checkOutput("post_drain.dataF.valid", 64'(dataF.valid), 64'd0);

        applyStimulus(1, 64'h8000_0200, 1, 32'h1111_1111, 0);
        checkReq("redir_dok", 1, 64'h8000_0200);
        checkOutput("redir_dok.dataF.valid", 64'(dataF.valid), 64'd0);

        applyStimulus(0, 64'h0, 1, 32'h2222_2222, 0);
        checkData("after_redir", 1, 64'h8000_0200, 32'h2222_2222);

        applyStimulus(1, 64'h8000_0300, 0, 32'h0, 0);
        checkOutput("out_flush.dataF.valid", 64'(dataF.valid), 64'd0);
        checkReq("out_flush", 1, 64'h8000_0300);

        applyStimulus(1, 64'h8000_0100, 0, 32'h0, 0);
        checkReq("dbl_drain0", 1, 64'h8000_0300);
        applyStimulus(1, 64'h8000_0200, 0, 32'h0, 0);
        checkReq("dbl_drain1", 1, 64'h8000_0300);
        applyStimulus(0, 64'h0, 1, 32'h4444_4444, 0);
        checkReq("dbl_target", 1, 64'h8000_0200);

        applyStimulus(1, 64'h8000_0103, 1, 32'h5555_5555, 0);
        checkReq("misaligned", 1, 64'h8000_0100);

        applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h6666_6666, 0);
        checkReq("wrap_req", 1, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(0, 64'h0, 1, 32'h0000_0033, 0);
        checkData("wrap_data", 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0033);
        applyStimulus(0, 64'h0, 0, 32'h0, 0);
        checkReq("wrap_next", 1, 64'h0);

        applyStimulus(1, 64'h8000_0400, 0, 32'h0, 0);
        checkReq("pre_reset_drain", 1, 64'h0);
        resetn = 1'b0;
        applyStimulus(0, 64'h0, 0, 32'h0, 0);
        checkReq("mid_reset", 0, 64'h0);
        checkData("mid_reset", 0, 64'h0, 32'h0);
        resetn = 1'b1;
        #1;
        checkReq("after_reset", 1, 64'h8000_0000);

        applyStimulus(0, 64'h0, 1, 32'h0000_0055, 1);
        checkData("stall_in_req", 1, 64'h8000_0000, 32'h0000_0055);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
